// File: rtl/mem_pkg.sv
// Shared definitions for the memory-to-stream reader.
// Holds the controller state encoding and the size of the beat buffer.
// Ports: none (package).
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for start
    ST_RUN   = 2'd1,  // reads still to be issued
    ST_DRAIN = 2'd2,  // all reads issued, beats still leaving
    ST_DONE  = 2'd3   // single-cycle completion
  } state_t;

  // Beat buffer depth and the width of its occupancy count (0..FIFO_DEPTH).
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CW    = 2;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry valid/ready buffer; out_data is driven straight from the head register.
// Ports: clk/rst_n; in_valid/in_ready/in_data (write side);
//        out_valid/out_ready/out_data (read side); count = current occupancy.
module stream_fifo2
  import mem_pkg::*;
#(
  parameter int DW = 33
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic [FIFO_CW-1:0] count
);

  localparam logic [FIFO_CW-1:0] FULL = FIFO_CW'(FIFO_DEPTH);
  localparam logic [FIFO_CW-1:0] ONE  = FIFO_CW'(1);

  logic [DW-1:0]      head_q, tail_q;
  logic [FIFO_CW-1:0] count_q;
  logic               push, pop;

  assign out_valid = (count_q != '0);
  // When full, a word can still enter in the same cycle the head leaves.
  assign in_ready  = (count_q != FULL) | out_ready;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = head_q;
  assign count     = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_q + FIFO_CW'(push) - FIFO_CW'(pop);
      // Head refills from the tail when full, otherwise directly from the input
      // if the buffer is (or is about to be) empty.
      if (pop && count_q == FULL)
        head_q <= tail_q;
      else if (push && (count_q == '0 || (pop && count_q == ONE)))
        head_q <= in_data;
      if (push && ((count_q == ONE && !pop) || count_q == FULL))
        tail_q <= in_data;
    end
  end

endmodule

// File: rtl/mem_stream_reader.sv
// Reads len consecutive words (wrapping at DEPTH) from a 1-cycle-latency memory
// and streams them out with valid/ready, marking the final beat with m_last.
// Ports: start/base_addr/len launch a burst; busy/done report progress;
//        mem_en/mem_addr/mem_dout drive the memory; m_valid/m_ready/m_data/m_last form the stream.
module mem_stream_reader
  import mem_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      len,
  output logic             busy,
  output logic             done,
  output logic             mem_en,
  output logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_dout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
);

  state_t            state_q, state_d;
  logic [AW-1:0]     next_addr_q, last_addr_q;
  logic [AW:0]       remaining_q;
  logic              inflight_q, inflight_last_q;
  logic [FIFO_CW-1:0] fifo_count;
  logic              fifo_in_ready;
  logic [WIDTH:0]    fifo_out_data;
  logic              pop, issue, last_issue;
  logic [2:0]        used;

  assign pop = m_valid & m_ready;

  // Credit check: words buffered plus the word in flight, less the one leaving
  // this cycle, must leave room for the read issued now.
  assign used       = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign issue      = (state_q == ST_RUN) && (used < (3'(FIFO_DEPTH) + {2'b00, pop}));
  assign last_issue = issue && (remaining_q == (AW+1)'(1));

  assign mem_en   = issue;
  assign mem_addr = issue ? next_addr_q : last_addr_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = (len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && m_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr_q     <= '0;
      last_addr_q     <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        next_addr_q <= base_addr;
        remaining_q <= len;
      end else if (issue) begin
        next_addr_q <= (next_addr_q == AW'(DEPTH - 1)) ? '0 : next_addr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
        last_addr_q <= next_addr_q;
      end
      // Read data appears one cycle after issue; remember whether it is the last word.
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
    end
  end

  stream_fifo2 #(.DW(WIDTH + 1)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inflight_q),
    .in_ready  (fifo_in_ready),
    .in_data   ({inflight_last_q, mem_dout}),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (fifo_out_data),
    .count     (fifo_count)
  );

  assign m_data = fifo_out_data[WIDTH-1:0];
  assign m_last = m_valid & fifo_out_data[WIDTH];

  // The credit check guarantees a returning word always finds room.
  assert property (@(posedge clk) disable iff (!rst_n) inflight_q |-> fifo_in_ready);

endmodule

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 Parameter WIDTH, default 32, data word width; SHALL match the attached memory.
REQ-002 Parameter DEPTH, default 512, memory depth; AW = ceil(log2(DEPTH)).
REQ-003 Port clk, input, 1, single clock; all state SHALL be clocked on its rising edge.
REQ-004 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 Port start, input, 1, launch request, sampled only in IDLE.
REQ-006 Port base_addr, input, AW, first word address, captured with start.
REQ-007 Port len, input, AW+1, word count (0..DEPTH), captured with start.
REQ-008 Port busy, output, 1, high in any state other than IDLE.
REQ-009 Port done, output, 1, one-cycle completion pulse.
REQ-010 Port mem_en, output, 1, memory read-port enable.
REQ-011 Port mem_addr, output, AW, memory read-port address.
REQ-012 Port mem_dout, input, WIDTH, memory read data, valid exactly 1 cycle after a cycle with mem_en=1.
REQ-013 Port m_valid, output, 1, stream beat valid.
REQ-014 Port m_ready, input, 1, stream sink ready.
REQ-015 Port m_data, output, WIDTH, stream beat data.
REQ-016 Port m_last, output, 1, final beat of the burst; qualified by m_valid.

Function
REQ-017 FSM states: IDLE, RUN (reads outstanding), DRAIN (all reads issued, beats pending), DONE (one cycle, done=1); DONE->IDLE unconditionally.
REQ-018 IDLE & start & len!=0 -> RUN; IDLE & start & len==0 -> DONE, with no read and no beat.
REQ-019 start while busy SHALL be ignored; base_addr/len changes while busy SHALL have no effect.
REQ-020 Read k (k=0..len-1) SHALL use address (base_addr+k) mod DEPTH (wrap-around).
REQ-021 Issued reads SHALL be captured into a 2-entry FIFO on the cycle after issue; m_data/m_valid SHALL be driven from the FIFO head register.
REQ-022 A read SHALL be issued only if (fifo_count + inflight - pop) < 2, where pop = m_valid & m_ready; the FIFO SHALL never overflow.
REQ-023 With m_ready held high, throughput SHALL be 1 beat/cycle; first m_valid SHALL assert 3 cycles after the start cycle.
REQ-024 Beats SHALL leave in address order; m_valid, once high, SHALL hold with m_data stable until m_ready.
REQ-025 m_last SHALL be 1 only on beat len-1.
REQ-026 RUN->DRAIN after read len-1 is issued; DRAIN->DONE on the handshake of the last beat; done SHALL be high on the following cycle.
REQ-027 mem_en SHALL be 0 outside RUN; mem_addr SHALL hold its last value when mem_en=0.

Reset
REQ-028 On rst_n=0, the block SHALL enter IDLE immediately, set busy, done, mem_en, m_valid, and m_last to 0, set mem_addr to 0, and empty the FIFO.
REQ-029 Reset mid-burst SHALL discard all pending beats; the next start after rst_n rises SHALL behave as a fresh burst.
REQ-030 m_data SHALL reset to 0.

Structure
REQ-031 The FSM state encoding and the FIFO depth constant (2) SHALL live in a shared package, mem_pkg.
REQ-032 The 2-entry FIFO SHALL be a sub-module, stream_fifo2 (WIDTH+1 bits incl. last, valid/ready both sides).
REQ-033 Target size: 120-400 lines RTL total.

Verification
REQ-034 Memory preloaded with mem[i]=i; base=5, len=4, m_ready=1 -> beats 5,6,7,8 on consecutive cycles; m_last on 8; done pulses once.
REQ-035 DEPTH=512, base=510, len=4 -> mem_addr sequence 510, 511, 0, 1; data in the same order.
REQ-036 len=0 -> done pulses 1 cycle after start; m_valid and mem_en never rise.
REQ-037 base=0, len=16, m_ready toggled pseudo-randomly -> 16 beats in order, none lost or duplicated, FIFO count never >2.
REQ-038 base=0, len=8, rst_n pulled low after 3 beats -> all outputs 0 asynchronously; a new start with base=100, len=2 yields exactly beats 100, 101.
REQ-039 base=0, len=DEPTH -> DEPTH beats, last=mem[DEPTH-1], busy deasserts after done.
